// File: rtl/flash_pkg.sv
// Shared constants and sizing helpers for the flash blink engine.
// Derived constants describe the default build; modules re-derive them from their own parameters.
// No datapath, no latency, no backpressure.
package flash_pkg;

    localparam int CLK_HZ_DEF     = 25000000;
    localparam int TICK_HZ_DEF    = 100;
    localparam int CHANNELS_DEF   = 4;
    localparam int PERIOD_W_DEF   = 8;
    localparam int DEF_PERIOD_DEF = 50;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int ch_w(input int ch);
        return (clog2(ch) < 1) ? 1 : clog2(ch);
    endfunction

    localparam int DIV      = CLK_HZ_DEF / TICK_HZ_DEF;
    localparam int PRE_W    = clog2(DIV);
    localparam int CH_W     = ch_w(CHANNELS_DEF);
    localparam int DEF_DUTY = DEF_PERIOD_DEF / 2;

endpackage

// File: rtl/flash_tick_gen.sv
// Base tick strobe: prescaler over CLK_HZ/TICK_HZ, or vsync rising edge when FLASH_FRAME_TICK_EN is defined.
// Latency: tick is registered, high for the one cycle after the terminal count (or after the vsync edge).
// Backpressure: none, free-running strobe.
module flash_tick_gen
    import flash_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEF,
    parameter int TICK_HZ = TICK_HZ_DEF
) (
    input  logic clock,
    input  logic reset,
`ifdef FLASH_FRAME_TICK_EN
    input  logic vsync,
`endif
    output logic tick
);

`ifdef FLASH_FRAME_TICK_EN
    logic vsync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            tick    <= vsync && !vsync_q;
        end
    end
`else
    localparam int CLK_DIV = CLK_HZ / TICK_HZ;
    localparam int CNT_W   = clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] pre;

    always_ff @(posedge clock) begin
        if (reset) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pre == LAST);
            pre  <= (pre == LAST) ? '0 : pre + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/flash_engine.sv
// Multi-channel blink generator with per-channel runtime period/duty; FLASH_FRAME_TICK_EN counts vsync frames instead of prescaled ticks.
// Latency: flash/flash_rise registered one clock after the phase/enable state they reflect.
// Backpressure: none; config writes always accepted, out-of-range channel writes dropped.
module flash_engine
    import flash_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int TICK_HZ    = TICK_HZ_DEF,
    parameter int CHANNELS   = CHANNELS_DEF,
    parameter int PERIOD_W   = PERIOD_W_DEF,
    parameter int DEF_PERIOD = DEF_PERIOD_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
`ifdef FLASH_FRAME_TICK_EN
    input  logic                       vsync,
`endif
    input  logic [CHANNELS-1:0]        enable,
    input  logic                       cfg_we,
    input  logic [ch_w(CHANNELS)-1:0]  cfg_chan,
    input  logic [PERIOD_W-1:0]        cfg_period,
    input  logic [PERIOD_W-1:0]        cfg_duty,
    output logic [CHANNELS-1:0]        flash,
    output logic [CHANNELS-1:0]        flash_rise,
    output logic                       tick
);

    localparam int SEL_W = ch_w(CHANNELS);
    localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(DEF_PERIOD);
    localparam logic [PERIOD_W-1:0] RST_DUTY   = PERIOD_W'(DEF_PERIOD / 2);
    localparam logic [PERIOD_W-1:0] ONE        = PERIOD_W'(1);

    flash_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clock (clock),
        .reset (reset),
`ifdef FLASH_FRAME_TICK_EN
        .vsync (vsync),
`endif
        .tick  (tick)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] duty;
        logic [PERIOD_W-1:0] phase;
        logic                flash_q;
        logic                rise_q;
        logic                wr;
        logic                flash_next;
        logic                wrap;

        // Channel indices past CHANNELS never match, so such writes fall away.
        assign wr         = cfg_we && (cfg_chan == SEL_W'(i));
        assign flash_next = enable[i] && (period != '0) && (phase < duty);
        assign wrap       = (phase == period - ONE);

        always_ff @(posedge clock) begin
            if (reset) begin
                period  <= RST_PERIOD;
                duty    <= RST_DUTY;
                phase   <= '0;
                flash_q <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                flash_q <= flash_next;
                rise_q  <= flash_next && !flash_q;
                // A config write restarts the phase even if a tick lands in the same cycle.
                if (wr) begin
                    period <= cfg_period;
                    duty   <= cfg_duty;
                    phase  <= '0;
                end else if (!enable[i] || period == '0) begin
                    phase <= '0;
                end else if (tick) begin
                    phase <= wrap ? '0 : phase + ONE;
                end
            end
        end

        assign flash[i]      = flash_q;
        assign flash_rise[i] = rise_q;
    end

endmodule

// File: tb/tb_flash_engine.sv
// Directed bench for flash_engine: expected outputs per cycle come from a tick-counting model and are queued, then popped after each edge.
`timescale 1ns/1ps
module tb_flash_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] enable = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_chan = '0;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_duty = '0;
    logic [3:0] flash;
    logic [3:0] flash_rise;
    logic       tick;

    logic [4:0] enable5 = '0;
    logic       cfg_we5 = 1'b0;
    logic [2:0] cfg_chan5 = '0;
    logic [7:0] cfg_period5 = '0;
    logic [7:0] cfg_duty5 = '0;
    logic [4:0] flash5;
    logic [4:0] flash_rise5;
    logic       tick5;
`ifdef FLASH_FRAME_TICK_EN
    logic       vsync = 1'b0;
    bit         vs_prev;
`endif

    always #5 clock = ~clock;

    flash_engine #(.CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(4), .PERIOD_W(8), .DEF_PERIOD(50)) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef FLASH_FRAME_TICK_EN
        .vsync      (vsync),
`endif
        .enable     (enable),
        .cfg_we     (cfg_we),
        .cfg_chan   (cfg_chan),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .flash      (flash),
        .flash_rise (flash_rise),
        .tick       (tick)
    );

    // Five channels give a 3-bit channel select, so selects 5..7 are out of range.
    flash_engine #(.CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(5), .PERIOD_W(8), .DEF_PERIOD(50)) dut5 (
        .clock      (clock),
        .reset      (reset),
`ifdef FLASH_FRAME_TICK_EN
        .vsync      (vsync),
`endif
        .enable     (enable5),
        .cfg_we     (cfg_we5),
        .cfg_chan   (cfg_chan5),
        .cfg_period (cfg_period5),
        .cfg_duty   (cfg_duty5),
        .flash      (flash5),
        .flash_rise (flash_rise5),
        .tick       (tick5)
    );

    typedef struct packed {
        logic [3:0] flash;
        logic [3:0] rise;
        logic       tick;
    } exp_t;

    exp_t       sbq[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         per[4];
    int         dty[4];
    int         rst_at[4];
    bit         en_prev[4];
    logic [3:0] f_prev;
    int         k;
    int         cum[0:8191];
    int         hi_cnt[4];
    int         rise_cnt[4];
    int         tick_cnt;
    int         guard;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    function automatic int ticks(input int a, input int b);
        if (b < a) return 0;
        return cum[b] - ((a > 0) ? cum[a-1] : 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            per[i] = 50;
            dty[i] = 25;
            rst_at[i] = 0;
            en_prev[i] = 1'b0;
        end
        f_prev = '0;
        k = 0;
        cum[0] = 0;
`ifdef FLASH_FRAME_TICK_EN
        vs_prev = 1'b0;
`endif
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            hi_cnt[i] = 0;
            rise_cnt[i] = 0;
        end
        tick_cnt = 0;
    endtask

    // One clock: predict the next sample from the model, clock, then check the DUT against the queue head.
    task automatic step();
        exp_t e;
        exp_t g;
        int   ph;
        e = '0;
        for (int i = 0; i < 4; i++)
            if (enable[i] && !en_prev[i]) rst_at[i] = k;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                ph = (per[i] == 0) ? 0 : ticks(rst_at[i], k - 1) % per[i];
                e.flash[i] = enable[i] && (per[i] != 0) && (ph < dty[i]);
                e.rise[i]  = e.flash[i] && !f_prev[i];
            end
`ifdef FLASH_FRAME_TICK_EN
            e.tick = vsync && !vs_prev;
            vs_prev = vsync;
`else
            e.tick = ((k + 1) % 10 == 0);
`endif
            if (cfg_we) begin
                per[cfg_chan] = int'(cfg_period);
                dty[cfg_chan] = int'(cfg_duty);
                rst_at[cfg_chan] = k + 1;
            end
        end
        for (int i = 0; i < 4; i++) en_prev[i] = enable[i];
        f_prev = e.flash;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        if (reset) model_reset();
        else begin
            k++;
            if (k > 8000) begin
                $display("FAIL cycle_budget k=%0d limit=8000", k);
                $fatal(1, "cycle budget exceeded");
            end
            cum[k] = cum[k-1] + (e.tick ? 1 : 0);
        end
        g = sbq.pop_front();
        chk("flash", {28'd0, flash}, {28'd0, g.flash});
        chk("flash_rise", {28'd0, flash_rise}, {28'd0, g.rise});
        chk("tick", {31'd0, tick}, {31'd0, g.tick});
        chk("tick5", {31'd0, tick5}, {31'd0, g.tick});
        for (int i = 0; i < 4; i++) begin
            hi_cnt[i]   += flash[i] ? 1 : 0;
            rise_cnt[i] += flash_rise[i] ? 1 : 0;
        end
        tick_cnt += tick ? 1 : 0;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] p, input logic [7:0] d);
        cfg_we = 1'b1;
        cfg_chan = ch;
        cfg_period = p;
        cfg_duty = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_counts();
        reset = 1'b1;
        run(3);
        reset = 1'b0;

`ifdef FLASH_FRAME_TICK_EN
        cfg(2'd0, 8'd2, 8'd1);
        enable = 4'b0001;
        step();
        clear_counts();
        for (int f = 0; f < 4; f++) begin
            vsync = 1'b1;
            step();
            vsync = 1'b0;
            run(19);
        end
        chk("frame_ticks", tick_cnt, 4);
        chk("frame_rises", rise_cnt[0], 2);
        clear_counts();
        vsync = 1'b1;
        run(5);
        vsync = 1'b0;
        run(15);
        chk("held_vsync_single_tick", tick_cnt, 1);
`else
        // Tick cadence with everything disabled
        clear_counts();
        run(100);
        chk("tick_count_100", tick_cnt, 10);
        chk("idle_flash_high", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

        // Basic blink: period 4 ticks, duty 1 tick; the write lands on a tick cycle
        cfg(2'd0, 8'd4, 8'd1);
        enable[0] = 1'b1;
        clear_counts();
        run(160);
        chk("blink_rises", rise_cnt[0], 4);
        chk("blink_high_cycles", hi_cnt[0], 40);

        // Edge duties and zero period
        cfg(2'd1, 8'd5, 8'd0);
        cfg(2'd2, 8'd5, 8'd7);
        cfg(2'd3, 8'd0, 8'd3);
        enable = 4'b1111;
        clear_counts();
        run(100);
        chk("duty0_rises", rise_cnt[1], 0);
        chk("duty_ge_period_rises", rise_cnt[2], 1);
        chk("duty_ge_period_high", hi_cnt[2], 100);
        chk("period0_high", hi_cnt[3], 0);
        cfg(2'd3, 8'd1, 8'd1);
        run(30);
        chk("period1_on", {31'd0, flash[3]}, 32'd1);

        // Write coinciding with a tick on ch0 while ch1 keeps counting
        cfg(2'd1, 8'd2, 8'd1);
        while (k % 10 != 0) step();
        cfg(2'd0, 8'd2, 8'd1);
        run(40);

        // Enable drop and return in the on-phase
        guard = 0;
        while (!f_prev[0] && guard < 50) begin
            step();
            guard++;
        end
        chk("found_on_phase", {31'd0, f_prev[0]}, 32'd1);
        enable[0] = 1'b0;
        step();
        chk("enable_drop", {31'd0, flash[0]}, 32'd0);
        enable[0] = 1'b1;
        step();
        chk("enable_return", {31'd0, flash[0]}, 32'd1);

        // Reset mid-operation restores 50/25 on every channel
        reset = 1'b1;
        step();
        chk("reset_flash", {28'd0, flash}, 32'd0);
        chk("reset_rise", {28'd0, flash_rise}, 32'd0);
        chk("reset_tick", {31'd0, tick}, 32'd0);
        reset = 1'b0;
        clear_counts();
        enable5 = 5'b11111;
        cfg_we5 = 1'b1;
        cfg_chan5 = 3'd5;
        step();
        cfg_chan5 = 3'd7;
        step();
        cfg_we5 = 1'b0;
        step();
        chk("oob_write_ignored", {27'd0, flash5}, 32'h1f);
        chk("oob_rise_quiet", {27'd0, flash_rise5}, 32'd0);
        cfg_we5 = 1'b1;
        cfg_chan5 = 3'd4;
        step();
        cfg_we5 = 1'b0;
        step();
        chk("ch4_write_applies", {27'd0, flash5}, 32'h0f);
        run(255);
        chk("default_duty_high", hi_cnt[0], 251);
        clear_counts();
        run(250);
        chk("default_period_rise", rise_cnt[0], 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
